bs_gnrtr_n_rbtr: RTL and testbench
==================================

BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

Interface
REQ-001 The block SHALL have the parameter drvrs, default 4, giving the number of attached devices (1..255).
REQ-002 The block SHALL have the parameter pckg_sz, default 16, giving the packet width in bits (>= 9).
REQ-003 The block SHALL have the parameter broadcast, default 8'hFF, giving the destination ID that means all devices.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have the port pndng, input, [drvrs-1:0]: device i's source FIFO is non-empty.
REQ-007 The block SHALL have the port D_pop, input, [drvrs-1:0][pckg_sz-1:0]: the head word of device i's FIFO; it is first-word-fall-through and valid while pndng[i]=1.
REQ-008 The block SHALL have the port pop, output, [drvrs-1:0]: a one-cycle pulse that removes the head of device i's FIFO.
REQ-009 The block SHALL have the port push, output, [drvrs-1:0]: a one-cycle pulse that writes D_push[i] into device i's sink.
REQ-010 The block SHALL have the port D_push, output, [drvrs-1:0][pckg_sz-1:0]: bus data, with the same packet driven on every lane.

Function
REQ-011 The packet format SHALL be: bits [pckg_sz-1:pckg_sz-8] = destination ID; bits [pckg_sz-9:0] = payload.
REQ-012 The packet SHALL be forwarded unmodified, with the destination field included.
REQ-013 The FSM SHALL have three states: IDLE -> POP -> PUSH -> IDLE. The FSM is Moore and all outputs are registered.
REQ-014 In IDLE, if pndng != 0 the block SHALL choose src by round-robin, latch D_pop[src] into pkt, set pop = onehot(src) and go to POP.
REQ-015 In IDLE, if pndng == 0 the block SHALL stay in IDLE with pop = 0 and push = 0.
REQ-016 In POP the block SHALL clear pop, load D_push[all lanes] = pkt and set push = mask, then go to PUSH.
REQ-017 In PUSH the block SHALL clear push and go to IDLE; this gives the FIFO one cycle to update pndng.
REQ-018 Throughput SHALL be one packet per 3 cycles, with latency of 1 cycle from grant edge to pop and 2 cycles from grant edge to push.
REQ-019 The push mask SHALL be onehot(dest) when dest < drvrs.
REQ-020 When dest == broadcast, the push mask SHALL be all ones except bit src.
REQ-021 When dest >= drvrs and dest != broadcast, the push mask SHALL be 0; the packet is popped and dropped.
REQ-022 When dest == src and dest is not broadcast, the push mask SHALL be onehot(src), i.e. loopback is allowed.
REQ-023 Round-robin SHALL search from (last_grant+1) mod drvrs upward with wrap-around and grant the first pndng bit found; last_grant updates on each grant.
REQ-024 Simultaneous requests SHALL each be served once before any requester is served twice.
REQ-025 pndng SHALL be sampled only in IDLE; changes in pndng during POP or PUSH SHALL be ignored.
REQ-026 D_push SHALL hold the last packet between transfers; it only changes on the POP->PUSH edge.

Reset
REQ-027 While reset = 0 the block SHALL immediately and asynchronously set state = IDLE, pop = 0, push = 0, D_push = 0, pkt = 0, and last_grant = drvrs-1 so that device 0 has first priority.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer: no push occurs, and the packet is lost if it was already popped.
REQ-029 The first grant decision SHALL occur on the first rising clk edge after reset deasserts.

Structure
REQ-030 A shared package bus_pkg SHALL hold: the state enum (IDLE, POP, PUSH), ID_W = 8, and a function extracting dest from a packet.
REQ-031 The round-robin selector SHALL be one sub-module, rr_arbiter (inputs req and last_grant; outputs grant index and valid), and SHALL be combinational.
REQ-032 The top level SHALL hold the FSM, the packet register and the output registers.

Verification
REQ-033 With drvrs=5 and pckg_sz=16 the bench SHALL check: pndng[1]=1, D_pop[1]=16'h0208 -> pop[1] pulses 1 cycle, then next cycle push = 5'b00100 and D_push lanes = 16'h0208.
REQ-034 The bench SHALL check broadcast: D_pop[3]=16'hFF55 -> pop[3] pulses, then push = 5'b10111 with all lanes = 16'hFF55.
REQ-035 The bench SHALL check round-robin: pndng = 5'b11111 held, each dest 0 -> pop sequence is devices 0, 1, 2, 3, 4, 0, with each grant 3 cycles apart.
REQ-036 The bench SHALL check invalid destination: D_pop[0]=16'h0711 (dest 7 >= 5, not FF) -> pop[0] pulses and push stays 0.
REQ-037 The bench SHALL check reset mid-operation: reset=0 during POP -> pop, push and D_push are 0 immediately, and after release device 0 is granted first.
REQ-038 The bench SHALL check the idle case: pndng = 0 for 100 cycles -> pop = push = 0 throughout and D_push unchanged.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus generator / arbiter.
// Holds the FSM state encoding and packet field extraction.
package bus_pkg;

   localparam int ID_W      = 8;
   localparam int MAX_PKT_W = 256;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_POP  = 2'd1;
   localparam logic [1:0] ST_PUSH = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      POP  = ST_POP,
      PUSH = ST_PUSH
   } state_t;

   // Destination ID sits in the top ID_W bits of a pkt_w-wide packet.
   function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                input int pkt_w);
      return pkt[pkt_w-1 -: ID_W];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: grants the first requester found
// searching upward from last_grant+1 with wrap-around.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [IW-1:0] grant,
   output logic          valid
);

   int          idx;
   logic [IW-1:0] sel;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int off = N; off >= 1; off--) begin
         idx = int'(last_grant) + off;
         if (idx >= N) idx = idx - N;
         sel = IW'(idx);
         if (req[sel]) begin
            grant = sel;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Bus generator and arbiter: pops one packet from a round-robin selected
// source FIFO and pushes it to the device(s) named by its destination ID.
//
// state | meaning
// IDLE  | sample pndng, grant a source, latch its head word, pulse pop
// POP   | drive packet on all lanes, pulse push with destination mask
// PUSH  | clear push, give the source FIFO a cycle to update pndng
module bs_gnrtr_n_rbtr
   import bus_pkg::*;
#(
   parameter int                drvrs     = 4,
   parameter int                pckg_sz   = 16,
   parameter logic [ID_W-1:0]   broadcast = 8'hFF
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [drvrs-1:0]                  pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]     D_pop,
   output logic [drvrs-1:0]                  pop,
   output logic [drvrs-1:0]                  push,
   output logic [drvrs-1:0][pckg_sz-1:0]     D_push
);

   localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

   state_t              state;
   logic [pckg_sz-1:0]  pkt;
   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       grant;
   logic                grant_vld;
   logic [ID_W-1:0]     dest;
   logic [drvrs-1:0]    mask;
   logic [drvrs-1:0]    grant_onehot;

   rr_arbiter #(.N(drvrs), .IW(IW)) u_rr_arbiter (
      .req        (pndng),
      .last_grant (last_grant),
      .grant      (grant),
      .valid      (grant_vld)
   );

   // last_grant doubles as the source of the packet in flight.
   always_comb begin
      dest         = get_dest(MAX_PKT_W'(pkt), pckg_sz);
      mask         = '0;
      grant_onehot = '0;
      for (int i = 0; i < drvrs; i++) begin
         grant_onehot[i] = (int'(grant) == i);
         if (dest == broadcast) mask[i] = (int'(last_grant) != i);
         else                   mask[i] = (int'(dest) == i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pop        <= '0;
         push       <= '0;
         D_push     <= '0;
         pkt        <= '0;
         last_grant <= IW'(drvrs - 1);
      end else begin
         case (state)
            IDLE: begin
               push <= '0;
               if (grant_vld) begin
                  pkt        <= D_pop[grant];
                  pop        <= grant_onehot;
                  last_grant <= grant;
                  state      <= POP;
               end else begin
                  pop <= '0;
               end
            end
            POP: begin
               pop    <= '0;
               push   <= mask;
               D_push <= {drvrs{pkt}};
               state  <= PUSH;
            end
            PUSH: begin
               push  <= '0;
               state <= IDLE;
            end
            default: begin
               pop   <= '0;
               push  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Self-checking bench for bs_gnrtr_n_rbtr: directed cases plus random
// traffic checked every cycle against a transaction-level model.
module tb_bs_gnrtr_n_rbtr;

   localparam int N = 5;
   localparam int W = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N-1:0]         pndng;
   logic [N-1:0][W-1:0]  D_pop;
   logic [N-1:0]         pop;
   logic [N-1:0]         push;
   logic [N-1:0][W-1:0]  D_push;

   bs_gnrtr_n_rbtr #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .D_pop  (D_pop),
      .pop    (pop),
      .push   (push),
      .D_push (D_push)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // source FIFOs as circular buffers
   logic [W-1:0] fbuf [N][64];
   int           rd [N];
   int           wr [N];

   // transaction model: busy counts the cycles left in a transfer
   int           busy;
   int           last_g;
   int           cur_src;
   logic [W-1:0] cur_pkt;
   logic [N-1:0] exp_pop;
   logic [N-1:0] exp_push;
   logic [W-1:0] exp_data;

   int           rr_dev[$];
   int           rr_cyc[$];
   int           pop_events;
   int           push_events;
   int           last_pop_dev;
   logic [N-1:0] last_mask;
   logic [W-1:0] last_data;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int d;
         d = (last + k) % N;
         if (req[d]) return d;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] ref_mask(input logic [W-1:0] p, input int s);
      int d;
      d = int'(p[W-1:W-8]);
      if (d == 255) return ~(N'(1) << s);
      if (d < N)    return N'(1) << d;
      return '0;
   endfunction

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         pndng[i] = (rd[i] != wr[i]);
         D_pop[i] = pndng[i] ? fbuf[i][rd[i] & 63] : W'($urandom);
      end
   endtask

   task automatic load(input int d, input logic [W-1:0] v);
      fbuf[d][wr[d] & 63] = v;
      wr[d]++;
   endtask

   task automatic model_reset();
      busy     = 0;
      last_g   = N - 1;
      exp_pop  = '0;
      exp_push = '0;
      exp_data = '0;
      for (int i = 0; i < N; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
   endtask

   task automatic step();
      int g;
      case (busy)
         0: begin
            exp_push = '0;
            exp_pop  = '0;
            g = rr_pick(pndng, last_g);
            if (g >= 0) begin
               last_g   = g;
               cur_src  = g;
               cur_pkt  = fbuf[g][rd[g] & 63];
               exp_pop  = N'(1) << g;
               rd[g]++;
               busy = 2;
            end
         end
         2: begin
            exp_pop  = '0;
            exp_push = ref_mask(cur_pkt, cur_src);
            exp_data = cur_pkt;
            busy = 1;
         end
         default: begin
            exp_push = '0;
            busy = 0;
         end
      endcase
      @(posedge clk);
      #1;
      cyc++;
      chk("pop", pop, exp_pop);
      chk("push", push, exp_push);
      chk("d_push", D_push, {N{exp_data}});
      if (pop != '0) begin
         pop_events++;
         for (int i = 0; i < N; i++) if (pop[i]) last_pop_dev = i;
         rr_dev.push_back(last_pop_dev);
         rr_cyc.push_back(cyc);
      end
      if (push != '0) begin
         push_events++;
         last_mask = push;
         last_data = D_push[0];
      end
      drive_inputs();
   endtask

   task automatic drain();
      int lim;
      int pending;
      lim = 0;
      pending = 1;
      while (pending != 0 && lim < 200) begin
         step();
         lim++;
         pending = (busy != 0) ? 1 : 0;
         for (int i = 0; i < N; i++) if (rd[i] != wr[i]) pending = 1;
      end
      chk("drain_bound", pending, 0);
   endtask

   task automatic single(input string tag, input int dev, input logic [W-1:0] v,
                         input logic [N-1:0] want_mask, input int want_pushes);
      int pe;
      pe = push_events;
      last_pop_dev = -1;
      load(dev, v);
      drive_inputs();
      repeat (4) step();
      chk({tag, "_pop_dev"}, last_pop_dev, dev);
      chk({tag, "_push_cnt"}, push_events - pe, want_pushes);
      if (want_pushes != 0) begin
         chk({tag, "_mask"}, last_mask, want_mask);
         chk({tag, "_data"}, last_data, v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq [6];
      int pe;
      int pc;
      int guard;
      exp_seq = '{0, 1, 2, 3, 4, 0};
      pop_events = 0;
      push_events = 0;
      last_mask = '0;
      last_data = '0;
      last_pop_dev = -1;
      reset = 1'b0;
      model_reset();
      drive_inputs();
      #2;
      chk("rst_pop", pop, 0);
      chk("rst_push", push, 0);
      chk("rst_dpush", D_push, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // round robin with all requesters held active
      for (int i = 0; i < N; i++) begin
         load(i, {8'h00, 8'(16 * i + 1)});
         load(i, {8'h00, 8'(16 * i + 2)});
      end
      drive_inputs();
      rr_dev.delete();
      rr_cyc.delete();
      repeat (18) step();
      chk("rr_count_ok", rr_dev.size() >= 6, 1);
      for (int k = 0; k < 6 && k < rr_dev.size(); k++) begin
         chk("rr_dev", rr_dev[k], exp_seq[k]);
         if (k > 0) chk("rr_gap", rr_cyc[k] - rr_cyc[k-1], 3);
      end
      drain();

      single("unicast", 1, 16'h0208, 5'b00100, 1);
      single("bcast",   3, 16'hFF55, 5'b10111, 1);
      single("invalid", 0, 16'h0711, 5'b00000, 0);
      single("loopbk",  2, 16'h02A5, 5'b00100, 1);

      // idle: nothing pending for 100 cycles
      pe = push_events;
      pc = pop_events;
      repeat (100) step();
      chk("idle_push_cnt", push_events - pe, 0);
      chk("idle_pop_cnt", pop_events - pc, 0);

      // reset asserted while in POP
      load(2, 16'h0133);
      drive_inputs();
      guard = 0;
      while (exp_pop == '0 && guard < 5) begin
         step();
         guard++;
      end
      chk("mid_reached_pop", pop, N'(1) << 2);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_pop", pop, 0);
      chk("mid_rst_push", push, 0);
      chk("mid_rst_dpush", D_push, 0);
      model_reset();
      drive_inputs();
      for (int i = 0; i < N; i++) load(i, 16'h02C0);
      drive_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      last_pop_dev = -1;
      pe = push_events;
      step();
      chk("post_rst_grant", last_pop_dev, 0);
      drain();
      chk("post_rst_pushes", push_events - pe, N);

      // random traffic
      for (int t = 0; t < 600; t++) begin
         if ($urandom_range(0, 9) < 4) begin
            int d;
            int r;
            logic [7:0] dst;
            d = $urandom_range(0, N - 1);
            r = $urandom_range(0, 9);
            if (r <= 4)      dst = 8'(r);
            else if (r <= 6) dst = 8'($urandom_range(5, 7));
            else if (r <= 8) dst = 8'hFF;
            else             dst = 8'($urandom);
            if (wr[d] - rd[d] < 60) load(d, {dst, 8'($urandom)});
            drive_inputs();
         end
         step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
